// File: rtl/mips_pkg.sv
// mips_pkg: shared load/store types, byte-enable patterns and alignment helper.
// No ports; imported by the LSU interface, lane aligner and controller.
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // size=11 is treated as misaligned so one test covers both errors
  function automatic logic lsu_misaligned(
    input lsu_size_t  sz,
    input logic [1:0] off
  );
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// lsu_bus_ctrl_if: req/ack data-memory bus between LSU (master) and memory (slave).
// Signals: bus_req/we/addr/be/wdata from master; bus_ack/rdata from slave.
interface lsu_bus_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for loads and stores.
// In: i_size/i_off/i_signed/i_wdata/i_rword. Out: o_be, o_wdata, o_rdata.
module lsu_lane_align
  import mips_pkg::*;
(
  input  lsu_size_t   i_size,
  input  logic [1:0]  i_off,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rword[7:0];
    case (i_off)
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      2'd3:    w_byte = i_rword[31:24];
      default: w_byte = i_rword[7:0];
    endcase
    w_half = i_off[1] ? i_rword[31:16]
                      : i_rword[15:0];
  end

  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_rdata = '0;
    case (i_size)
      SZ_BYTE: begin
        o_be    = BE_BYTE << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_byte[7]}},
                   w_byte};
      end
      SZ_HALF: begin
        o_be    = BE_HALF << i_off;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_half[15]}},
                   w_half};
      end
      SZ_WORD: begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: begin
        o_be    = '0;
        o_wdata = '0;
        o_rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store stage; runs one access over the req/ack bus, stalls the core.
// Core side: mem_read/mem_write/size/load_signed/addr/wdata -> stall/rdata/addr_err/bus_err; bus: master modport.
module lsu_bus_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  lsu_bus_ctrl_if.master bus
);

  lsu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  logic             r_signed;
  lsu_size_t        r_size;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_abort;

  logic        w_req;
  logic        w_bad;
  logic        w_go;
  logic        w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rd;

  assign w_req = mem_read | mem_write;
  assign w_bad = w_req &
                 ((mem_read & mem_write) |
                  lsu_misaligned(lsu_size_t'(size),
                                 addr[1:0]));
  assign w_go  = (r_state == IDLE) &
                 w_req & ~w_bad;
  assign w_tmo = (r_cnt ==
                  CNT_W'(TIMEOUT_CYCLES - 1));

  lsu_lane_align u_align (
    .i_size   (r_size),
    .i_off    (r_addr[1:0]),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .i_rword  (bus.bus_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rd)
  );

  // IDLE-cycle stall/addr_err are combinational; gate with reset
  // so every output is 0 while reset is held
  assign stall    = ~reset &
                    ((r_state == WAIT) | w_go);
  assign addr_err = ~reset &
                    (r_state == IDLE) & w_bad;
  assign rdata    = (r_state == DONE) ? r_rdata
                                      : '0;
  assign bus_err  = (r_state == DONE) & r_abort;

  assign bus.bus_req   = r_req;
  assign bus.bus_we    = r_req & r_we;
  assign bus.bus_addr  = r_req ? {r_addr[31:2], 2'b00}
                               : '0;
  assign bus.bus_be    = r_req ? w_be    : '0;
  assign bus.bus_wdata = r_req ? w_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= SZ_BYTE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_abort  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_abort <= 1'b0;
          r_rdata <= '0;
          if (w_go) begin
            r_state  <= WAIT;
            r_req    <= 1'b1;
            r_we     <= mem_write;
            r_signed <= load_signed;
            r_size   <= lsu_size_t'(size);
            r_addr   <= addr;
            r_wdata  <= wdata;
          end
        end
        WAIT: begin
          // ack has priority over a same-cycle timeout
          if (bus.bus_ack) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_rdata <= r_we ? '0 : w_rd;
          end else if (w_tmo) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_abort <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store stage directly downstream of the ALU. It takes the ALU result as the effective address and runs byte, halfword and word loads and stores over a req/ack data-memory bus.
- It stalls the core while an access is outstanding, and it aligns and extends load data for register writeback.
- It detects misaligned accesses, illegal requests and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT before abort; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  load requested this cycle.
- mem_write  in  1  store requested this cycle.
- size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- load_signed  in  1  1=sign-extend byte/half loads, 0=zero-extend.
- addr  in  32  effective address (ALU result).
- wdata  in  32  store data (rt register), right-justified.
- stall  out  1  hold PC/pipeline while high.
- rdata  out  32  extended load data; valid in the DONE cycle only.
- addr_err  out  1  misaligned or illegal request; one-cycle pulse.
- bus_err  out  1  timeout abort; one-cycle pulse.
- bus_req  out  1  bus request; registered.
- bus_we  out  1  1=write.
- bus_addr  out  32  word address: {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  one-cycle completion strobe from memory.
- bus_rdata  in  32  read word; valid with bus_ack.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; timeout counter 0; latched address, size and data cleared. Reset mid-transaction drops bus_req immediately. An ack that arrives after reset is ignored.
- An access is valid when exactly one of mem_read/mem_write is high.
- Alignment rules:
  - size=11 is illegal.
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - mem_read and mem_write both high is illegal.
- State IDLE:
  - Valid and aligned access: stall=1 combinationally. Latch addr, size, load_signed and we; form be/wdata; go to WAIT.
  - Illegal or misaligned access: addr_err=1 for that cycle, stall=0, no bus activity, stay in IDLE.
  - No request: stall=0.
- State WAIT:
  - bus_req=1, stall=1; the counter increments each cycle.
  - bus_ack=1: capture bus_rdata and go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE with abort flag set.
  - Ack and timeout in the same cycle: ack wins, no bus_err.
- State DONE:
  - bus_req=0, stall=0. rdata holds the extended data (0 on abort); bus_err=1 if aborted.
  - Next state is IDLE unconditionally; the core's next instruction is sampled in IDLE on the following cycle.
- Minimum latency: ack in the first WAIT cycle gives stall high for 2 cycles (IDLE, WAIT); DONE is the 3rd cycle.
- Byte enables by size:
  - Byte: be = 0001 << addr[1:0].
  - Half: be = 0011 << addr[1:0] (offset 0 or 2).
  - Word: be = 1111.
- Store data: byte replicated {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged. Memory writes only the enabled lanes.
- Load select (little-endian):
  - Byte = bus_rdata[8*off +: 8].
  - Half = bus_rdata[16*off[1] +: 16].
  - Extension by the latched load_signed.
- bus_addr, bus_we, bus_be and bus_wdata are held stable for the whole of WAIT. They are 0 in IDLE and DONE.
- bus_ack outside WAIT is ignored.

Decomposition:
- Shared package mips_pkg:
  - lsu_size_t enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL.
  - lsu_state_t enum: IDLE, WAIT, DONE.
  - Constants for byte-enable patterns.
- One sub-module, lsu_lane_align: combinational. Computes be and replicated wdata from size/offset, and extracted/extended rdata from size/offset/signed. It is reused by any future cache path.

Test Plan:
- Word load at addr=0x0000_0010, ack on 1st WAIT cycle with bus_rdata=0xDEADBEEF -> bus_addr=0x10, be=1111, stall high 2 cycles, rdata=0xDEADBEEF in DONE.
- Signed byte load at addr=0x13, bus_rdata=0x80FF_7F01 -> rdata=0xFFFFFF80. Unsigned byte load at the same address -> rdata=0x00000080.
- Half store at addr=0x22, wdata=0x1234_ABCD -> be=1100, bus_wdata=0xABCDABCD, bus_we=1; ack after 3 cycles -> stall held 4 cycles.
- Word load at addr=0x06 -> addr_err one cycle, bus_req never asserted, stall=0. Both mem_read and mem_write high -> addr_err.
- TIMEOUT_CYCLES=4, no ack -> bus_err pulse in DONE, rdata=0, return to IDLE. Ack on the exact timeout cycle -> normal completion, no bus_err.
- reset asserted during WAIT -> bus_req and stall 0 in the same cycle; a later stray ack causes no output change.
